uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
- Data width is a parameter. Baud divisor and stop-bit count are selected at run time and latched per frame.
- Uses a valid/ready handshake and allows back-to-back frames. Parity is an optional compile-time feature.
- Sits between the bus slave register interface and the serial pin.

Parameters:
- DATA_LEN, 8, payload bits per frame (5..9), sent LSB first.
- DIV_W, 16, width of the run-time baud divisor.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clks_per_bit  in  DIV_W  bit period in clk cycles; sampled at accept; 0 and 1 are treated as 2
- stop2  in  1  1 = two stop bits, 0 = one stop bit; sampled at accept
- send_valid  in  1  frame request
- data  in  DATA_LEN  payload; sampled at accept
- send_ready  out  1  high when a request can be accepted
- tx_busy  out  1  frame in progress
- tx_data  out  1  serial line; idles high
- tx_done  out  1  one-cycle pulse at frame end
- parity_en  in  1  (UART_TX_PARITY_EN only) insert parity bit
- parity_odd  in  1  (UART_TX_PARITY_EN only) 1 = odd parity, 0 = even parity

Behaviour:
- Clocking/reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: tx_data=1, tx_busy=0, tx_done=0, send_ready=1, state=IDLE, all counters 0.
- Reset mid-frame: the line returns high immediately, the frame is discarded, and no tx_done is issued.
- Accept: occurs on the edge where send_valid && send_ready.
  - data, the divisor N (clamped to ≥2) and stop2 are latched; parity settings are also latched when the feature is compiled in.
  - From that edge: send_ready=0, tx_busy=1, tx_data=0 (start bit begins).
- Registers: all outputs are registered. Input changes after accept have no effect on the frame in flight.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Bit timing:
  - Every bit lasts exactly N cycles, counted by clk_cnt from 0 to N-1.
  - The state or bit advances when clk_cnt==N-1.
  - DATA sends data[0] through data[DATA_LEN-1] in order.
  - STOP drives 1 for N cycles, or 2N cycles when stop2 is set.
- Frame length: B = 1 + DATA_LEN + P + S bits, where P∈{0,1} and S∈{1,2}. The frame spans B·N cycles starting at the accept edge.
- End of frame: on the edge ending the last stop bit:
  - state=IDLE, tx_done=1 for one cycle;
  - tx_busy=0 and send_ready=1 in that same cycle;
  - tx_data stays 1.
- Back-to-back frames: a request present during the tx_done cycle is accepted on the next edge. The minimum inter-frame gap is therefore 1 idle cycle beyond the stop bits.
- send_valid while busy is ignored, not queued. The requester must hold send_valid until it sees send_ready.
- Counter width: clk_cnt is DIV_W bits. The bit counter is $clog2(DATA_LEN+1) bits.
- No wrap-around: the maximum divisor is 2^DIV_W-1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - parity_en and parity_odd ports exist.
  - If the latched parity_en=1, a PARITY state follows DATA for N cycles.
  - Parity bit = ^data XOR parity_odd.
- Undefined: the ports and the PARITY state are absent, and P=0 always.

Decomposition:
- Package uart_pkg:
  - state encoding localparams IDLE/START/DATA/PARITY/STOP;
  - MIN_DIV=2;
  - function frame_bits(data_len, parity, stop2);
  - parity function.
- Sub-module uart_baud_tick:
  - holds the latched divisor and clk_cnt;
  - outputs bit_end when clk_cnt==N-1;
  - clears on the frame-start strobe.
- The FSM stays in uart_tx_cfg.

Test Plan:
- Basic frame: DATA_LEN=8, N=4, stop2=0, data=0xA5, no parity -> line bits 0,1,0,1,0,0,1,0,1,1, each exactly 4 cycles; tx_done on cycle 40 after accept; tx_busy high cycles 0..39.
- Two stop bits: N=3, stop2=1, data=0x00 -> start plus 8 zeros (27 cycles low), then 6 cycles high; tx_done at cycle 33.
- Back-to-back: send_valid held high, data 0x55 then 0x0F, N=2 -> second start bit begins exactly 1 cycle after the first tx_done; both bytes decode correctly.
- Divisor clamp and mid-frame changes: clks_per_bit=0 -> 2-cycle bits. Changing clks_per_bit and data mid-frame does not alter the frame in flight.
- Reset mid-frame: assert reset during DATA bit 3 -> tx_data=1 asynchronously; no tx_done; send_ready=1 after release; the next frame is correct.
- Parity (UART_TX_PARITY_EN): data=0x07 with even parity -> parity bit 1; with odd parity -> 0. Frame is 11 bits; tx_done at 11·N.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, divisor floor and frame helpers for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int MIN_DIV = 2;

    function automatic int frame_bits(input int data_len, input logic parity, input logic stop2);
        return 1 + data_len + int'(parity) + (stop2 ? 2 : 1);
    endfunction

    // Payload is zero-extended to 9 bits so one function covers every DATA_LEN.
    function automatic logic parity_bit(input logic [8:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: per-frame bit-period counter with a latched, clamped divisor
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   i_start    in   frame-start strobe: latch divisor, clear counter
//   i_div      in   requested bit period in clk cycles (values below 2 become 2)
//   i_run      in   frame in progress
//   o_bit_end  out  high in the last cycle of the current bit
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_run,
    output logic             o_bit_end
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;

    assign o_bit_end = i_run && (r_cnt == r_div - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_div <= (i_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_div;
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= o_bit_end ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with valid/ready request and run-time baud/stop selection
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   clks_per_bit  in   bit period in clk cycles, latched at accept (0/1 treated as 2)
//   stop2         in   two stop bits when set, latched at accept
//   send_valid    in   frame request
//   data          in   payload, sent LSB first, latched at accept
//   parity_en     in   insert parity bit (only with UART_TX_PARITY_EN)
//   parity_odd    in   odd parity when set, even otherwise (only with UART_TX_PARITY_EN)
//   send_ready    out  request can be accepted
//   tx_busy       out  frame in progress
//   tx_data       out  serial line, idles high
//   tx_done       out  one-cycle pulse at frame end
// Build option: define UART_TX_PARITY_EN to add the parity ports and PARITY state.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_LEN = 8,
    parameter int DIV_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIV_W-1:0]    clks_per_bit,
    input  logic                stop2,
    input  logic                send_valid,
    input  logic [DATA_LEN-1:0] data,
`ifdef UART_TX_PARITY_EN
    input  logic                parity_en,
    input  logic                parity_odd,
`endif
    output logic                send_ready,
    output logic                tx_busy,
    output logic                tx_data,
    output logic                tx_done
);

    localparam int BW = $clog2(DATA_LEN + 1);

    state_t              r_state, w_state_n;
    logic [DATA_LEN-1:0] r_data, w_data_n;
    logic [BW-1:0]       r_bit, w_bit_n;
    logic                r_stop2;
    logic                r_second, w_second_n;
    logic                r_tx, w_tx_n;
    logic                r_done, w_done_n;
    logic                r_busy, w_busy_n;
    logic                r_ready, w_ready_n;
    logic                w_accept;
    logic                w_bit_end;
    logic                w_par_en;
    logic                w_par_bit;

    assign w_accept   = send_valid && r_ready;
    assign send_ready = r_ready;
    assign tx_busy    = r_busy;
    assign tx_data    = r_tx;
    assign tx_done    = r_done;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_accept),
        .i_div     (clks_per_bit),
        .i_run     (r_busy),
        .o_bit_end (w_bit_end)
    );

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_par_en  <= parity_en;
            r_par_bit <= parity_bit(9'(data), parity_odd);
        end
    end

    assign w_par_en  = r_par_en;
    assign w_par_bit = r_par_bit;
`else
    assign w_par_en  = 1'b0;
    assign w_par_bit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_data   <= '0;
            r_bit    <= '0;
            r_stop2  <= 1'b0;
            r_second <= 1'b0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_data   <= w_data_n;
            r_bit    <= w_bit_n;
            r_stop2  <= w_accept ? stop2 : r_stop2;
            r_second <= w_second_n;
            r_tx     <= w_tx_n;
            r_done   <= w_done_n;
            r_busy   <= w_busy_n;
            r_ready  <= w_ready_n;
        end
    end

    // The payload register shifts right once per finished data bit, so bit 1
    // is always the next data bit to drive.
    always_comb begin
        w_state_n  = r_state;
        w_data_n   = r_data;
        w_bit_n    = r_bit;
        w_second_n = r_second;
        w_tx_n     = r_tx;
        w_done_n   = 1'b0;
        w_busy_n   = r_busy;
        w_ready_n  = r_ready;
        case (r_state)
            IDLE: if (w_accept) begin
                w_state_n = START;
                w_data_n  = data;
                w_bit_n   = '0;
                w_tx_n    = 1'b0;
                w_busy_n  = 1'b1;
                w_ready_n = 1'b0;
            end
            START: if (w_bit_end) begin
                w_state_n = DATA;
                w_tx_n    = r_data[0];
            end
            DATA: if (w_bit_end) begin
                if (r_bit == BW'(DATA_LEN - 1)) begin
                    w_state_n  = w_par_en ? PARITY : STOP;
                    w_tx_n     = w_par_en ? w_par_bit : 1'b1;
                    w_second_n = 1'b0;
                end else begin
                    w_bit_n  = r_bit + 1'b1;
                    w_data_n = r_data >> 1;
                    w_tx_n   = r_data[1];
                end
            end
            PARITY: if (w_bit_end) begin
                w_state_n  = STOP;
                w_tx_n     = 1'b1;
                w_second_n = 1'b0;
            end
            STOP: if (w_bit_end) begin
                if (r_stop2 && !r_second) begin
                    w_second_n = 1'b1;
                end else begin
                    w_state_n = IDLE;
                    w_done_n  = 1'b1;
                    w_busy_n  = 1'b0;
                    w_ready_n = 1'b1;
                    w_tx_n    = 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

endmodule
